// File: rtl/reg_spill_fill_if.sv
// Bus bundle for the register spill/fill engine: control operands in, register-file
// and data-memory pointers, strobes and data out. "master" is the controller and
// storage side, "slave" is the engine.
interface reg_spill_fill_if #(
  parameter int pw = 4,
  parameter int aw = 8
);
  logic          start;
  logic          dir;
  logic [pw-1:0] first_reg;
  logic [pw:0]   count;
  logic [aw-1:0] mem_base;
  logic [pw-1:0] rf_rd_addr;
  logic [7:0]    rf_rd_dat;
  logic          rf_wr_en;
  logic [pw-1:0] rf_wr_addr;
  logic [7:0]    rf_wr_dat;
  logic [aw-1:0] dm_addr;
  logic          dm_wr_en;
  logic [7:0]    dm_wr_dat;
  logic [7:0]    dm_rd_dat;
  logic          busy;
  logic          done;

  modport master (
    output start, dir, first_reg, count, mem_base, rf_rd_dat, dm_rd_dat,
    input  rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_dat,
    input  dm_addr, dm_wr_en, dm_wr_dat, busy, done
  );

  modport slave (
    input  start, dir, first_reg, count, mem_base, rf_rd_dat, dm_rd_dat,
    output rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_dat,
    output dm_addr, dm_wr_en, dm_wr_dat, busy, done
  );
endinterface

// File: rtl/reg_spill_fill.sv
// Block-transfer engine between the register file and data memory. Moves one
// register per clock over a contiguous (wrapping) register range, either spilling
// registers to memory or filling registers from memory. All strobes and pointers
// are decoded from registered state so nothing glitches on operand changes.
module reg_spill_fill #(
  parameter int pw = 4,
  parameter int aw = 8
) (
  input logic               clk,
  input logic               reset,
  reg_spill_fill_if.slave   bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Largest meaningful count: the whole register file.
  localparam logic [pw:0] MAX_CNT = {1'b1, {pw{1'b0}}};

  logic [1:0]    state_q, state_d;
  logic          dir_q,   dir_d;
  logic [pw-1:0] idx_q,   idx_d;
  logic [aw-1:0] addr_q,  addr_d;
  logic [pw:0]   rem_q,   rem_d;

  logic [pw:0]   eff_cnt;
  logic          in_xfer;

  // Counts above the register-file size would only revisit registers; clamp them.
  assign eff_cnt = (bus.count > MAX_CNT) ? MAX_CNT : bus.count;

  // Next-state logic: latch operands on start, then step index/address once per cycle.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          dir_d   = bus.dir;
          idx_d   = bus.first_reg;
          addr_d  = bus.mem_base;
          rem_d   = eff_cnt;
          state_d = (eff_cnt != '0) ? XFER : DONE;
        end
      end
      XFER: begin
        // Index and address wrap naturally at their widths.
        idx_d  = idx_q + 1'b1;
        addr_d = addr_q + 1'b1;
        rem_d  = rem_q - 1'b1;
        if (rem_q == (pw+1)'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Clear the walk registers so a stale pointer never lingers into IDLE.
        idx_d   = '0;
        addr_d  = '0;
        rem_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and operand registers; an asynchronous reset abandons any transfer at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      idx_q   <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
    end
  end

  assign in_xfer = (state_q == XFER);

  // Pointers are forced to zero outside XFER; the read pointer only moves for a
  // spill and the write pointer only for a fill.
  assign bus.rf_rd_addr = (in_xfer && !dir_q) ? idx_q  : '0;
  assign bus.rf_wr_addr = (in_xfer &&  dir_q) ? idx_q  : '0;
  assign bus.dm_addr    =  in_xfer            ? addr_q : '0;

  assign bus.dm_wr_en   = in_xfer && !dir_q;
  assign bus.rf_wr_en   = in_xfer &&  dir_q;

  // Data is a straight cross-connection; the strobes decide which side commits.
  assign bus.dm_wr_dat  = bus.rf_rd_dat;
  assign bus.rf_wr_dat  = bus.dm_rd_dat;

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);

endmodule
